// File: rtl/ccm_lsu_pkg.sv
// ---------------------------------------------------------------------------
// ccm_lsu_pkg
//   Shared definitions for the CCM load/store port:
//     - request size encodings carried on req_size
//     - FSM state type used by ccm_lsu_port
//     - lane widths used by the alignment logic
// ---------------------------------------------------------------------------
package ccm_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        RMW_WAIT  = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/ccm_lsu_align.sv
// ---------------------------------------------------------------------------
// ccm_lsu_align
//   Purely combinational lane logic for the CCM load/store port.
//     word      : word returned by the controller (or forwarded write data)
//     size      : SZ_BYTE / SZ_HALF / SZ_WORD
//     lane      : byte address bits [1:0]
//     ld_signed : sign-extend sub-word load results
//     st_wdata  : right-aligned store data
//     ld_rdata  : extracted and extended load result
//     st_word   : word with the store byte(s) merged into their lane(s)
// ---------------------------------------------------------------------------
module ccm_lsu_align
    import ccm_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            size,
    input  logic [1:0]            lane,
    input  logic                  ld_signed,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [DATA_WIDTH-1:0] st_word
);

    logic [BYTE_W-1:0] ld_byte;
    logic [HALF_W-1:0] ld_half;

    // Byte k sits at bits [8k+7:8k]; half h sits at bits [16h+15:16h].
    always_comb begin
        ld_byte  = word[{lane, 3'b000} +: BYTE_W];
        ld_half  = word[{lane[1], 4'b0000} +: HALF_W];
        ld_rdata = word;
        case (size)
            SZ_BYTE: ld_rdata = {{(DATA_WIDTH-BYTE_W){ld_signed & ld_byte[BYTE_W-1]}}, ld_byte};
            SZ_HALF: ld_rdata = {{(DATA_WIDTH-HALF_W){ld_signed & ld_half[HALF_W-1]}}, ld_half};
            default: ld_rdata = word;
        endcase
    end

    always_comb begin
        st_word = word;
        case (size)
            SZ_BYTE: st_word[{lane, 3'b000} +: BYTE_W]    = st_wdata[BYTE_W-1:0];
            SZ_HALF: st_word[{lane[1], 4'b0000} +: HALF_W] = st_wdata[HALF_W-1:0];
            default: st_word = st_wdata;
        endcase
    end

endmodule

// File: rtl/ccm_lsu_port.sv
// ---------------------------------------------------------------------------
// ccm_lsu_port
//   Core-side initiator for the CCM controller. Turns byte/half/word LSU
//   requests into word-wide controller reads and writes; sub-word stores are
//   done as read-modify-write because the controller has no byte enables.
//   A read of the word written in the previous cycle would see stale data
//   (the controller registers its write), so such requests are stalled one
//   cycle, or, with CCM_LSU_FWD_EN defined, served from the last written word.
//
//   Optional feature macro: CCM_LSU_FWD_EN (write-to-read forwarding).
//
//   Ports
//     clk, rst_n                 clock, asynchronous active-low reset
//     req_valid / req_ready      request handshake
//     req_we, req_addr, req_size,
//     req_signed, req_wdata      request fields (byte address, right-aligned data)
//     resp_valid, resp_rdata,
//     resp_err                   one-cycle response pulse
//     cntlr_rd, cntlr_raddr      controller read strobe / word address
//     cntlr_rd_data,
//     cntlr_rd_valid             read return, one cycle after cntlr_rd
//     cntlr_wr, cntlr_waddr,
//     cntlr_wr_data              controller write strobe / word address / data
// ---------------------------------------------------------------------------
module ccm_lsu_port
    import ccm_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  cntlr_rd,
    output logic [ADDR_WIDTH-1:0] cntlr_raddr,
    input  logic [DATA_WIDTH-1:0] cntlr_rd_data,
    input  logic                  cntlr_rd_valid,
    output logic                  cntlr_wr,
    output logic [ADDR_WIDTH-1:0] cntlr_waddr,
    output logic [DATA_WIDTH-1:0] cntlr_wr_data
);

    lsu_state_e state, state_nxt;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [1:0]            lane;
    logic                  misalign;
    logic                  needs_rd;
    logic                  hazard;
    logic                  fwd_hit;
    logic                  accept;
    logic                  advance;
    logic                  use_fwd;

    // Request fields captured at acceptance
    logic [1:0]            size_p1;
    logic [1:0]            lane_p1;
    logic                  signed_p1;
    logic [DATA_WIDTH-1:0] wdata_p1;
    logic [ADDR_WIDTH-1:0] waddr_p1;

    logic                  last_wr;
    logic [ADDR_WIDTH-1:0] last_waddr;

    logic [DATA_WIDTH-1:0] src_word;
    logic [DATA_WIDTH-1:0] ld_rdata;
    logic [DATA_WIDTH-1:0] st_word;

    logic                  resp_valid_nxt;
    logic                  resp_err_nxt;
    logic [DATA_WIDTH-1:0] resp_rdata_nxt;

    assign word_addr = req_addr[ADDR_WIDTH+1:2];
    assign lane      = req_addr[1:0];

    assign misalign = (req_size == 2'd3)
                    || (req_size == SZ_HALF && lane[0])
                    || (req_size == SZ_WORD && lane != 2'd0);

    // Loads and sub-word stores read the word first; word stores never do.
    assign needs_rd = !misalign && !(req_we && req_size == SZ_WORD);

    assign hazard = last_wr && req_valid && needs_rd && (word_addr == last_waddr);

`ifdef CCM_LSU_FWD_EN
    logic [DATA_WIDTH-1:0] last_wdata;
    logic                  fwd_p1;

    // last_wdata only changes on a write, so it still holds the colliding
    // word in the wait state after a forwarded request was accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wdata <= '0;
            fwd_p1     <= 1'b0;
        end else begin
            if (cntlr_wr)
                last_wdata <= cntlr_wr_data;
            if (accept)
                fwd_p1 <= fwd_hit;
        end
    end

    assign req_ready = rst_n && (state == IDLE);
    assign fwd_hit   = hazard;
    assign use_fwd   = fwd_p1;
    assign src_word  = fwd_p1 ? last_wdata : cntlr_rd_data;
`else
    assign req_ready = rst_n && (state == IDLE) && !hazard;
    assign fwd_hit   = 1'b0;
    assign use_fwd   = 1'b0;
    assign src_word  = cntlr_rd_data;
`endif

    assign accept  = req_valid && req_ready;
    assign advance = use_fwd || cntlr_rd_valid;

    ccm_lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .word      (src_word),
        .size      (size_p1),
        .lane      (lane_p1),
        .ld_signed (signed_p1),
        .st_wdata  (wdata_p1),
        .ld_rdata  (ld_rdata),
        .st_word   (st_word)
    );

    always_comb begin
        state_nxt      = state;
        cntlr_rd       = 1'b0;
        cntlr_raddr    = '0;
        cntlr_wr       = 1'b0;
        cntlr_waddr    = '0;
        cntlr_wr_data  = '0;
        resp_valid_nxt = 1'b0;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = '0;
        case (state)
            IDLE: begin
                // Stray or stale read returns are ignored here.
                if (accept) begin
                    if (misalign) begin
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                    end else if (req_we && req_size == SZ_WORD) begin
                        cntlr_wr       = 1'b1;
                        cntlr_waddr    = word_addr;
                        cntlr_wr_data  = req_wdata;
                        resp_valid_nxt = 1'b1;
                    end else begin
                        cntlr_rd    = !fwd_hit;
                        cntlr_raddr = fwd_hit ? '0 : word_addr;
                        state_nxt   = req_we ? RMW_WAIT : LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                if (advance) begin
                    resp_valid_nxt = 1'b1;
                    resp_rdata_nxt = ld_rdata;
                    state_nxt      = IDLE;
                end
            end
            RMW_WAIT: begin
                if (advance) begin
                    cntlr_wr       = 1'b1;
                    cntlr_waddr    = waddr_p1;
                    cntlr_wr_data  = st_word;
                    resp_valid_nxt = 1'b1;
                    state_nxt      = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage boundary: accept -> wait state / response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            size_p1    <= '0;
            lane_p1    <= '0;
            signed_p1  <= 1'b0;
            wdata_p1   <= '0;
            waddr_p1   <= '0;
            last_wr    <= 1'b0;
            last_waddr <= '0;
        end else begin
            state      <= state_nxt;
            resp_valid <= resp_valid_nxt;
            resp_err   <= resp_err_nxt;
            resp_rdata <= resp_rdata_nxt;
            if (accept) begin
                size_p1   <= req_size;
                lane_p1   <= lane;
                signed_p1 <= req_signed;
                wdata_p1  <= req_wdata;
                waddr_p1  <= word_addr;
            end
            last_wr    <= cntlr_wr;
            last_waddr <= cntlr_waddr;
        end
    end

endmodule

// File: tb/tb_ccm_lsu_port.sv
module tb_ccm_lsu_port;
    import ccm_lsu_pkg::*;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW+1:0] req_addr = '0;
    logic [1:0]    req_size = '0;
    logic          req_signed = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          cntlr_rd;
    logic [AW-1:0] cntlr_raddr;
    logic [DW-1:0] cntlr_rd_data = '0;
    logic          cntlr_rd_valid = 1'b0;
    logic          cntlr_wr;
    logic [AW-1:0] cntlr_waddr;
    logic [DW-1:0] cntlr_wr_data;

    always #5 clk = ~clk;

    ccm_lsu_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .cntlr_rd       (cntlr_rd),
        .cntlr_raddr    (cntlr_raddr),
        .cntlr_rd_data  (cntlr_rd_data),
        .cntlr_rd_valid (cntlr_rd_valid),
        .cntlr_wr       (cntlr_wr),
        .cntlr_waddr    (cntlr_waddr),
        .cntlr_wr_data  (cntlr_wr_data)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- controller model (16 words used) ----------------
    // Writes are registered: a write strobed in cycle T lands in the array at
    // the end of T+1, so a read strobed in T+1 sees the old word.
    logic [31:0] cmem [16];
    logic        pend_wr = 1'b0;
    logic [3:0]  pend_addr = '0;
    logic [31:0] pend_data = '0;
    logic        stray = 1'b0;
    logic        bd_en = 1'b0;
    logic [3:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        cntlr_rd_valid <= cntlr_rd | stray;
        if (cntlr_rd) cntlr_rd_data <= cmem[cntlr_raddr[3:0]];
        else          cntlr_rd_data <= $urandom;
        if (pend_wr) cmem[pend_addr] <= pend_data;
        if (bd_en)   cmem[bd_addr] <= bd_data;
        pend_wr   <= cntlr_wr;
        pend_addr <= cntlr_waddr[3:0];
        pend_data <= cntlr_wr_data;
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [16];

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    function automatic exp_t model(input logic we, input logic [12:0] addr, input logic [1:0] size,
                                   input logic sgn, input logic [31:0] wd, input int acc);
        exp_t e;
        int wa, b, nb;
        logic [31:0] w, v;
        wa = int'(addr[12:2]);
        b  = int'(addr[1:0]);
        nb = 1 << size;
        e.acc = acc;
        e.rd  = 32'h0;
        e.err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && b != 0);
        if (e.err) begin
            e.lat = 1;
            return e;
        end
        w = ref_mem[wa[3:0]];
        if (we) begin
            for (int i = 0; i < nb; i++) w[8*(b+i) +: 8] = wd[8*i +: 8];
            ref_mem[wa[3:0]] = w;
            e.lat = (size == 2'd2) ? 1 : 2;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(b+i) +: 8];
            if (sgn && nb < 4 && v[8*nb-1])
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            e.rd  = v;
            e.lat = 2;
        end
        return e;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding, rdata=%h err=%b", resp_rdata, resp_err);
            end else begin
                mon_e = sbq.pop_front();
                check("resp_err", {31'h0, resp_err}, {31'h0, mon_e.err});
                check("resp_rdata", resp_rdata, mon_e.rd);
                check("resp_latency", cyc - mon_e.acc, mon_e.lat);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic        s_rd, s_wr;
    logic [10:0] s_raddr, s_waddr;
    logic [31:0] s_wdata;
    int          s_stall;

    task automatic memset(input int w, input logic [31:0] v);
        @(negedge clk);
        bd_en   = 1'b1;
        bd_addr = w[3:0];
        bd_data = v;
        ref_mem[w[3:0]] = v;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [12:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wd;
        #2;
        while (!req_ready) begin
            n++;
            if (n > 16) begin
                n_vec++;
                n_bad++;
                $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #2;
        end
        s_stall = n;
        s_rd    = cntlr_rd;
        s_raddr = cntlr_raddr;
        s_wr    = cntlr_wr;
        s_waddr = cntlr_waddr;
        s_wdata = cntlr_wr_data;
        sbq.push_back(model(we, addr, size, sgn, wd, cyc));
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    logic        r_we, r_sgn;
    logic [1:0]  r_sz, r_ln;
    logic [10:0] r_w, prev_w;
    logic [31:0] r_wd;

    initial begin
        // Reset state, with a word store presented to prove the strobes are held off
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SZ_WORD;
        req_addr  = 13'h010;
        req_wdata = 32'h12345678;
        for (int i = 0; i < 16; i++) memset(i, $urandom);
        #2;
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_cntlr_rd", {31'h0, cntlr_rd}, 32'h0);
        check("rst_cntlr_wr", {31'h0, cntlr_wr}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_waddr", {21'h0, cntlr_waddr}, 32'h0);
        check("rst_wr_data", cntlr_wr_data, 32'h0);
        check("rst_raddr", {21'h0, cntlr_raddr}, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Word store: write strobed in the accept cycle
        issue(1'b1, 13'h010, SZ_WORD, 1'b0, 32'hDEADBEEF);
        check("wst_wr", {31'h0, s_wr}, 32'h1);
        check("wst_waddr", {21'h0, s_waddr}, 32'h4);
        check("wst_wdata", s_wdata, 32'hDEADBEEF);
        check("wst_rd", {31'h0, s_rd}, 32'h0);
        repeat (3) @(negedge clk);

        // Signed / unsigned byte loads
        memset(4, 32'h80112233);
        issue(1'b0, 13'h013, SZ_BYTE, 1'b1, 32'h0);
        check("ldb_rd", {31'h0, s_rd}, 32'h1);
        check("ldb_raddr", {21'h0, s_raddr}, 32'h4);
        issue(1'b0, 13'h013, SZ_BYTE, 1'b0, 32'h0);
        repeat (3) @(negedge clk);

        // Half store read-modify-write
        memset(4, 32'h11223344);
        issue(1'b1, 13'h012, SZ_HALF, 1'b0, 32'h0000A5A5);
        check("rmw_rd", {31'h0, s_rd}, 32'h1);
        check("rmw_raddr", {21'h0, s_raddr}, 32'h4);
        @(negedge clk);
        #2;
        check("rmw_wr", {31'h0, cntlr_wr}, 32'h1);
        check("rmw_waddr", {21'h0, cntlr_waddr}, 32'h4);
        check("rmw_wdata", cntlr_wr_data, 32'hA5A53344);
        repeat (3) @(negedge clk);

        // Write-then-read hazard on the same word
        issue(1'b1, 13'h020, SZ_WORD, 1'b0, 32'hCAFEF00D);
        issue(1'b0, 13'h020, SZ_WORD, 1'b0, 32'h0);
`ifdef CCM_LSU_FWD_EN
        check("haz_stall", s_stall, 32'h0);
        check("haz_rd", {31'h0, s_rd}, 32'h0);
`else
        check("haz_stall", s_stall, 32'h1);
        check("haz_rd", {31'h0, s_rd}, 32'h1);
`endif
        repeat (3) @(negedge clk);

        // Misaligned and illegal-size requests make no controller access
        issue(1'b0, 13'h011, SZ_HALF, 1'b0, 32'h0);
        check("mis_rd", {31'h0, s_rd}, 32'h0);
        check("mis_wr", {31'h0, s_wr}, 32'h0);
        issue(1'b1, 13'h010, 2'd3, 1'b0, 32'hFFFFFFFF);
        check("sz3_rd", {31'h0, s_rd}, 32'h0);
        check("sz3_wr", {31'h0, s_wr}, 32'h0);
        repeat (3) @(negedge clk);

        // Randomized traffic over 16 words, biased toward reusing the last word
        prev_w = '0;
        for (int i = 0; i < 400; i++) begin
            r_we  = 1'($urandom_range(0, 1));
            r_sgn = 1'($urandom_range(0, 1));
            r_wd  = $urandom;
            r_w   = ($urandom_range(0, 2) == 0) ? prev_w : 11'($urandom_range(0, 15));
            r_sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_ln  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (r_sz == SZ_HALF) r_ln[0] = 1'b0;
                if (r_sz == SZ_WORD) r_ln = 2'd0;
            end
            issue(r_we, {r_w, r_ln}, r_sz, r_sgn, r_wd);
            prev_w = r_w;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        repeat (4) @(negedge clk);

        // Reset while a load is waiting for its read return
        issue(1'b0, 13'h008, SZ_WORD, 1'b0, 32'h0);
        void'(sbq.pop_back());
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("midrst_req_ready", {31'h0, req_ready}, 32'h0);
        rst_n = 1'b1;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2;
            check("postrst_resp_valid", {31'h0, resp_valid}, 32'h0);
            check("postrst_req_ready", {31'h0, req_ready}, 32'h1);
        end
        issue(1'b0, 13'h00C, SZ_HALF, 1'b1, 32'h0);

        // Drain outstanding responses
        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain_outstanding", sbq.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
